// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment digit scanner.
//   SEG_NIBBLE_W : width of one digit code
//   BCD_MAX      : largest code treated as a displayable decimal digit
//   scan_state_e : per-slot scan phase (lit window, then blanking guard)
package seg_pkg;

    localparam int SEG_NIBBLE_W = 4;
    localparam int BCD_MAX      = 9;

    typedef enum logic {
        ST_ON    = 1'b0,
        ST_GUARD = 1'b1
    } scan_state_e;

endpackage

// File: rtl/seg_slot_timer.sv
// Slot timer for the digit scanner: counts cycles within a digit slot, splits each slot
// into an ON window followed by a GUARD window, advances the digit index at the end of a
// slot and pulses frame_tick on the last cycle of the final digit's slot.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   state       : current scan phase (ST_ON / ST_GUARD)
//   digit_idx   : digit whose slot is in progress
//   frame_tick  : high for the last cycle of digit NUM_DIGITS-1's slot
module seg_slot_timer
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SLOT_CYC   = 50000,
    parameter int unsigned GUARD_CYC  = 500,
    localparam int unsigned IDX_W     = $clog2(NUM_DIGITS)
) (
    input  logic             clk,
    input  logic             rst,
    output scan_state_e      state,
    output logic [IDX_W-1:0] digit_idx,
    output logic             frame_tick
);

    localparam int unsigned CNT_W = $clog2(SLOT_CYC);

    localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(SLOT_CYC - GUARD_CYC - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYC - 1);
    // frame_tick is registered, so it is computed one cycle ahead of the slot's last cycle
    localparam logic [CNT_W-1:0] TICK_PRE  = CNT_W'(SLOT_CYC - 2);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] slot_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt   <= '0;
            digit_idx  <= '0;
            state      <= ST_ON;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= (digit_idx == IDX_LAST) && (slot_cnt == TICK_PRE);
            case (state)
                ST_ON: begin
                    slot_cnt <= slot_cnt + CNT_W'(1);
                    if (slot_cnt == ON_LAST) begin
                        state <= ST_GUARD;
                    end
                end
                ST_GUARD: begin
                    if (slot_cnt == SLOT_LAST) begin
                        slot_cnt  <= '0;
                        digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + IDX_W'(1);
                        state     <= ST_ON;
                    end else begin
                        slot_cnt <= slot_cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_ON;
            endcase
        end
    end

endmodule

// File: rtl/seg_digit_scanner.sv
// Time-multiplexed scan controller for an N-digit 7-segment display.
// Holds an active frame of 4-bit codes plus a blank mask, drives the current digit's code
// to the decoder inputs and enables one digit per slot, with an all-dark guard at the end
// of every slot. New frames arrive via valid/ready into a one-deep pending buffer and are
// only promoted to the active frame at a frame boundary, so a frame never tears.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   load_valid  : upstream offers a frame
//   load_ready  : pending buffer is free (registered)
//   load_data   : frame codes, digit i in bits [4i+3:4i], digit 0 rightmost
//   load_blank  : per-digit dark mask for the offered frame
//   w,x,y,z     : current digit code to the decoder (w = bit3, z = bit0)
//   digit_en    : one-hot digit drive, active-low when EN_ACT_LOW
//   digit_idx   : digit whose slot is in progress
//   frame_tick  : pulse on the last cycle of digit NUM_DIGITS-1's slot
module seg_digit_scanner
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SLOT_CYC   = 50000,
    parameter int unsigned GUARD_CYC  = 500,
    parameter bit          EN_ACT_LOW = 1'b1,
    parameter bit          BCD_ONLY   = 1'b1,
    localparam int unsigned IDX_W     = $clog2(NUM_DIGITS),
    localparam int unsigned DATA_W    = SEG_NIBBLE_W * NUM_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [DATA_W-1:0]     load_data,
    input  logic [NUM_DIGITS-1:0] load_blank,
    output logic                  w,
    output logic                  x,
    output logic                  y,
    output logic                  z,
    output logic [NUM_DIGITS-1:0] digit_en,
    output logic [IDX_W-1:0]      digit_idx,
    output logic                  frame_tick
);

    // XOR mask that turns an active-high one-hot into the pin polarity
    localparam logic [NUM_DIGITS-1:0] EN_OFF = EN_ACT_LOW ? '1 : '0;

    scan_state_e scan_state;

    seg_slot_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .SLOT_CYC   (SLOT_CYC),
        .GUARD_CYC  (GUARD_CYC)
    ) u_slot_timer (
        .clk        (clk),
        .rst        (rst),
        .state      (scan_state),
        .digit_idx  (digit_idx),
        .frame_tick (frame_tick)
    );

    logic [DATA_W-1:0]       active_data;
    logic [NUM_DIGITS-1:0]   active_blank;
    logic [DATA_W-1:0]       pend_data;
    logic [NUM_DIGITS-1:0]   pend_blank;
    logic                    pend_full;
    logic                    pend_full_d;
    logic                    xfer;
    logic                    commit;
    logic [SEG_NIBBLE_W-1:0] nib_q;

    assign xfer   = load_valid & load_ready;
    // ready implies an empty pending buffer, so xfer and commit never coincide
    assign commit = frame_tick & pend_full;

    always_comb begin
        pend_full_d = pend_full;
        if (xfer) begin
            pend_full_d = 1'b1;
        end else if (commit) begin
            pend_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_full    <= 1'b0;
            load_ready   <= 1'b1;
            pend_data    <= '0;
            pend_blank   <= '0;
            active_data  <= '0;
            active_blank <= '1;
        end else begin
            pend_full  <= pend_full_d;
            load_ready <= ~pend_full_d;
            if (xfer) begin
                pend_data  <= load_data;
                pend_blank <= load_blank;
            end
            if (commit) begin
                active_data  <= pend_data;
                active_blank <= pend_blank;
            end
        end
    end

    // Select the in-slot digit's code, mask bit and one-hot enable
    logic [SEG_NIBBLE_W-1:0] cur_nib;
    logic                    cur_masked;
    logic [NUM_DIGITS-1:0]   cur_onehot;
    logic                    cur_dark;
    logic [NUM_DIGITS-1:0]   en_next;

    always_comb begin
        cur_nib    = '0;
        cur_masked = 1'b0;
        cur_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx == IDX_W'(i)) begin
                cur_nib       = active_data[i*SEG_NIBBLE_W +: SEG_NIBBLE_W];
                cur_masked    = active_blank[i];
                cur_onehot[i] = 1'b1;
            end
        end
    end

    assign cur_dark = cur_masked || (BCD_ONLY && (cur_nib > SEG_NIBBLE_W'(BCD_MAX)));
    assign en_next  = ((scan_state == ST_ON) && !cur_dark) ? cur_onehot : '0;

    // Code follows the active frame in every phase; it only moves with digit_idx or a
    // commit, both of which happen as a slot begins, while all digits are still dark.
    always_ff @(posedge clk) begin
        if (rst) begin
            nib_q    <= '0;
            digit_en <= EN_OFF;
        end else begin
            nib_q    <= cur_nib;
            digit_en <= en_next ^ EN_OFF;
        end
    end

    assign {w, x, y, z} = nib_q;

endmodule

// File: tb/tb_seg_digit_scanner.sv
module tb_seg_digit_scanner;

    localparam int NUM = 4;
    localparam int SLOT = 8;
    localparam int GUARD = 2;
    localparam logic [3:0] OFF = 4'hF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = 16'h0;
    logic [3:0]  load_blank = 4'h0;
    logic        load_ready;
    logic        w, x, y, z;
    logic [3:0]  digit_en;
    logic [1:0]  digit_idx;
    logic        frame_tick;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seg_digit_scanner #(
        .NUM_DIGITS (NUM),
        .SLOT_CYC   (SLOT),
        .GUARD_CYC  (GUARD),
        .EN_ACT_LOW (1'b1),
        .BCD_ONLY   (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_blank (load_blank),
        .w          (w),
        .x          (x),
        .y          (y),
        .z          (z),
        .digit_en   (digit_en),
        .digit_idx  (digit_idx),
        .frame_tick (frame_tick)
    );

    typedef struct packed {
        logic [1:0] idx;
        logic [3:0] nib;
        logic [3:0] en;
        logic [3:0] on;
    } slot_t;

    slot_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_slot(input logic [1:0] i, input logic [3:0] n, input logic [3:0] e,
                             input logic [3:0] o);
        slot_t s;
        s.idx = i;
        s.nib = n;
        s.en  = e;
        s.on  = o;
        exp_q.push_back(s);
    endtask

    // Returns at the negedge where frame_tick is high; n = negedges waited
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 100);
        check("frame_tick_seen", 32'(frame_tick), 32'd1);
    endtask

    // Called at a negedge; returns at the negedge after the transfer edge
    task automatic send(input logic [15:0] d, input logic [3:0] m);
        int n;
        load_valid = 1'b1;
        load_data  = d;
        load_blank = m;
        n = 0;
        while (!load_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", 32'(load_ready), 32'd1);
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    // Monitor: a slot starts when digit_idx changes; outputs lag by one cycle, so the slot
    // is observed over the following SLOT negedges and then compared with the queue head.
    initial begin : monitor
        int         phase;
        int         on_cnt;
        bit         armed;
        bit         nib_moved;
        slot_t      cur;
        logic [1:0] prev_idx;
        logic [1:0] idx_seen;
        logic [3:0] nib;
        logic [3:0] nib0;
        logic [3:0] en_seen;
        phase     = -1;
        on_cnt    = 0;
        armed     = 1'b0;
        nib_moved = 1'b0;
        prev_idx  = 2'd0;
        idx_seen  = 2'd0;
        nib0      = 4'h0;
        en_seen   = OFF;
        cur       = '0;
        forever begin
            @(negedge clk);
            nib = {w, x, y, z};
            if (phase >= 0) phase++;
            if (phase >= 1) begin
                if (phase == 1) begin
                    nib0     = nib;
                    idx_seen = digit_idx;
                end else if (nib != nib0) begin
                    nib_moved = 1'b1;
                end
                if (digit_en != OFF) begin
                    on_cnt++;
                    en_seen = digit_en;
                end
                if (phase == SLOT && armed) begin
                    check("slot_idx", 32'(idx_seen), 32'(cur.idx));
                    check("slot_nibble", 32'(nib0), 32'(cur.nib));
                    check("slot_nibble_stable", 32'(nib_moved), 32'd0);
                    check("slot_digit_en", 32'(en_seen), 32'(cur.en));
                    check("slot_lit_cycles", 32'(on_cnt), 32'(cur.on));
                    armed = 1'b0;
                end
            end
            if (digit_idx != prev_idx) begin
                phase     = 0;
                on_cnt    = 0;
                nib_moved = 1'b0;
                en_seen   = OFF;
                armed     = 1'b0;
                if (exp_q.size() > 0) begin
                    cur   = exp_q.pop_front();
                    armed = 1'b1;
                end
            end
            prev_idx = digit_idx;
        end
    end

    initial begin : stimulus
        int n;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state (cycle 0)
        check("rst_ready", 32'(load_ready), 32'd1);
        check("rst_tick", 32'(frame_tick), 32'd0);
        check("rst_en", 32'(digit_en), 32'(OFF));
        check("rst_nibble", 32'({w, x, y, z}), 32'd0);
        check("rst_idx", 32'(digit_idx), 32'd0);

        // 1: idle scan with all-dark default mask
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            check("idle_idx", 32'(digit_idx), 32'((c / SLOT) % NUM));
            check("idle_tick", 32'(frame_tick), 32'(c == 31));
            check("idle_en", 32'(digit_en), 32'(OFF));
        end

        // 2: 0x4321, nothing masked
        send(16'h4321, 4'b0000);
        check("ready_after_xfer", 32'(load_ready), 32'd0);
        wait_tick(n);
        push_slot(2'd0, 4'h1, 4'b1110, 4'd6);
        push_slot(2'd1, 4'h2, 4'b1101, 4'd6);
        push_slot(2'd2, 4'h3, 4'b1011, 4'd6);
        push_slot(2'd3, 4'h4, 4'b0111, 4'd6);

        // 3: 0x1234 accepted, 0x5678 held valid until the slot frees up
        load_valid = 1'b1;
        load_data  = 16'h1234;
        load_blank = 4'b0000;
        n = 0;
        while (!load_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("hold_first_ready", 32'(load_ready), 32'd1);
        @(negedge clk);
        load_data = 16'h5678;
        check("hold_ready_low", 32'(load_ready), 32'd0);
        wait_tick(n);
        check("hold_ready_at_tick", 32'(load_ready), 32'd0);
        push_slot(2'd0, 4'h4, 4'b1110, 4'd6);
        push_slot(2'd1, 4'h3, 4'b1101, 4'd6);
        push_slot(2'd2, 4'h2, 4'b1011, 4'd6);
        push_slot(2'd3, 4'h1, 4'b0111, 4'd6);
        @(negedge clk);
        check("hold_ready_after_commit", 32'(load_ready), 32'd1);
        @(negedge clk);
        check("hold_second_taken", 32'(load_ready), 32'd0);
        load_valid = 1'b0;
        wait_tick(n);
        push_slot(2'd0, 4'h8, 4'b1110, 4'd6);
        push_slot(2'd1, 4'h7, 4'b1101, 4'd6);
        push_slot(2'd2, 4'h6, 4'b1011, 4'd6);
        push_slot(2'd3, 4'h5, 4'b0111, 4'd6);

        // 4: non-BCD codes go dark but still drive their code
        send(16'h9A0F, 4'b0000);
        wait_tick(n);
        push_slot(2'd0, 4'hF, OFF, 4'd0);
        push_slot(2'd1, 4'h0, 4'b1101, 4'd6);
        push_slot(2'd2, 4'hA, OFF, 4'd0);
        push_slot(2'd3, 4'h9, 4'b0111, 4'd6);

        // masked digits
        send(16'h8765, 4'b1010);
        wait_tick(n);
        push_slot(2'd0, 4'h5, 4'b1110, 4'd6);
        push_slot(2'd1, 4'h6, OFF, 4'd0);
        push_slot(2'd2, 4'h7, 4'b1011, 4'd6);
        push_slot(2'd3, 4'h8, OFF, 4'd0);

        // 5: transfer on the frame_tick cycle; previous frame must persist one more frame
        wait_tick(n);
        push_slot(2'd0, 4'h5, 4'b1110, 4'd6);
        push_slot(2'd1, 4'h6, OFF, 4'd0);
        push_slot(2'd2, 4'h7, 4'b1011, 4'd6);
        push_slot(2'd3, 4'h8, OFF, 4'd0);
        send(16'h2468, 4'b0000);
        check("tick_load_ready_low", 32'(load_ready), 32'd0);
        wait_tick(n);
        // one negedge already passed inside send, so the tick is 32 cycles after the load
        check("tick_load_commit_gap", 32'(n + 1), 32'd32);
        push_slot(2'd0, 4'h8, 4'b1110, 4'd6);
        push_slot(2'd1, 4'h6, 4'b1101, 4'd6);
        push_slot(2'd2, 4'h4, 4'b1011, 4'd6);
        push_slot(2'd3, 4'h2, 4'b0111, 4'd6);

        // 6: one-cycle reset mid-slot with a frame pending
        wait_tick(n);
        send(16'h1111, 4'b0000);
        repeat (3) @(negedge clk);
        check("pre_reset_drained", 32'(exp_q.size()), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_ready", 32'(load_ready), 32'd1);
        check("mid_rst_tick", 32'(frame_tick), 32'd0);
        check("mid_rst_en", 32'(digit_en), 32'(OFF));
        check("mid_rst_nibble", 32'({w, x, y, z}), 32'd0);
        check("mid_rst_idx", 32'(digit_idx), 32'd0);
        wait_tick(n);
        check("mid_rst_tick_cycle", 32'(n), 32'd31);
        check("mid_rst_ready_at_tick", 32'(load_ready), 32'd1);
        push_slot(2'd0, 4'h0, OFF, 4'd0);
        push_slot(2'd1, 4'h0, OFF, 4'd0);
        push_slot(2'd2, 4'h0, OFF, 4'd0);
        push_slot(2'd3, 4'h0, OFF, 4'd0);
        repeat (40) @(negedge clk);
        check("final_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
